// File: rtl/encoder_4_2_evt.sv
// Registered N-to-log2(N) priority event encoder: captures rising edges on I_i as pending
// events and presents them one at a time on y_o with a valid/ready handshake.
// Optional macro ONEHOT_CHECK_EN adds an err_o pulse when several edges land in one cycle.
module encoder_4_2_evt #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [N-1:0] I_i,
  input  logic         ready_i,
  output logic [W-1:0] y_o,
  output logic         valid_o,
  output logic         ovf_o,
  output logic         err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] I_q;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] y_q, y_d;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;

  logic [N-1:0] risingEdge;
  logic [N-1:0] capture;
  logic [N-1:0] clr;
  logic [W-1:0] sel;
  logic         anyPending;

  assign risingEdge = I_i & ~I_q;
  assign capture    = en_i ? risingEdge : '0;
  assign anyPending = |pending_q;

  // Later iterations overwrite earlier ones, so the highest set index wins.
  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++) begin
      if (pending_q[k]) sel = W'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    valid_d = valid_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (anyPending) begin
          y_d     = sel;
          clr     = {{(N-1){1'b0}}, 1'b1} << sel;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready_i) begin
          if (anyPending) begin
            y_d = sel;
            clr = {{(N-1){1'b0}}, 1'b1} << sel;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge on the line being handed off re-queues it rather than counting as lost.
  assign pending_d = (pending_q & ~clr) | capture;
  assign ovf_d     = |(capture & pending_q & ~clr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      I_q       <= '0;
      pending_q <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      I_q       <= I_i;
      pending_q <= pending_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef ONEHOT_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= ($countones(capture) > 1);
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign y_o     = y_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;

endmodule
